auth_attempt_ctrl: RTL and testbench

Attempt-sequencing stage directly upstream of the key comparator. It accepts 8-bit key attempts over a valid/ready handshake and drives the candidate onto the comparator's key bus. It samples the comparator's match result and issues grant or deny. After repeated failures it enforces an exponentially growing lockout, and it scrubs the candidate bus after every evaluation.

---
 rtl/citadel_auth_pkg.sv | 16 +
 rtl/auth_lock_timer.sv | 39 +++
 rtl/auth_attempt_ctrl.sv | 111 +++++++++++
 tb/tb_auth_attempt_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/citadel_auth_pkg.sv
// Shared types and constants for the authentication attempt path.
package citadel_auth_pkg;

    localparam int KEY_W      = 8;
    localparam int FAIL_CNT_W = 4;

    localparam logic [KEY_W-1:0] SCRUB_KEY = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EVAL    = 2'd1,
        GRANTED = 2'd2,
        LOCKOUT = 2'd3
    } auth_state_t;

endpackage

// File: rtl/auth_lock_timer.sv
// Lockout down-counter with exponential backoff; lock_lvl saturates at MAX_SHIFT.
module auth_lock_timer #(
    parameter int LOCK_CYCLES = 16,
    parameter int MAX_SHIFT   = 3,
    parameter int TIMER_W     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clr_lvl,
    output logic expire
);

    localparam int LVL_W = (MAX_SHIFT < 1) ? 1 : $clog2(MAX_SHIFT + 1);
    localparam logic [TIMER_W-1:0] BASE    = TIMER_W'(LOCK_CYCLES);
    localparam logic [LVL_W-1:0]   LVL_MAX = LVL_W'(MAX_SHIFT);

    logic [TIMER_W-1:0] timer;
    logic [LVL_W-1:0]   lock_lvl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer    <= '0;
            lock_lvl <= '0;
        end else begin
            // Length uses the level before this lockout bumps it.
            if (load) begin
                timer <= BASE << lock_lvl;
                if (lock_lvl != LVL_MAX) lock_lvl <= lock_lvl + LVL_W'(1);
            end else if (timer != '0) begin
                timer <= timer - TIMER_W'(1);
            end
            if (clr_lvl) lock_lvl <= '0;
        end
    end

    assign expire = (timer == TIMER_W'(1));

endmodule

// File: rtl/auth_attempt_ctrl.sv
// Key-attempt sequencer: drives the comparator, issues grant/deny, enforces backoff lockout.
module auth_attempt_ctrl
    import citadel_auth_pkg::*;
#(
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int MAX_SHIFT   = 3,
    parameter int TIMER_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  attempt_valid,
    input  logic [KEY_W-1:0]      attempt_key,
    output logic                  attempt_ready,
    output logic [KEY_W-1:0]      cmp_key,
    input  logic                  cmp_match,
    input  logic                  session_clear,
    output logic                  granted,
    output logic                  deny_pulse,
    output logic                  locked,
    output logic [FAIL_CNT_W-1:0] fail_cnt,
    output auth_state_t           dbg_state
);

    // Handshake: an attempt transfers on a rising edge where attempt_valid and
    // attempt_ready are both 1; upstream holds attempt_key stable until then,
    // and ready never depends on valid.

    auth_state_t           state_q, state_d;
    logic [KEY_W-1:0]      cmp_key_d;
    logic                  deny_d;
    logic [FAIL_CNT_W-1:0] fail_d, fail_inc;
    logic                  load_lock, clr_lvl, lock_expire;

    assign attempt_ready = (state_q == IDLE) && rst_n;
    assign granted       = (state_q == GRANTED);
    assign locked        = (state_q == LOCKOUT);
    assign dbg_state     = state_q;
    assign fail_inc      = fail_cnt + FAIL_CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cmp_key_d = cmp_key;
        deny_d    = 1'b0;
        fail_d    = fail_cnt;
        load_lock = 1'b0;
        clr_lvl   = 1'b0;
        case (state_q)
            IDLE: begin
                if (attempt_valid && attempt_ready) begin
                    cmp_key_d = attempt_key;
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                cmp_key_d = SCRUB_KEY;
                if (cmp_match) begin
                    state_d = GRANTED;
                    fail_d  = '0;
                    clr_lvl = 1'b1;
                end else begin
                    deny_d = 1'b1;
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_CNT_W'(MAX_FAILS)) begin
                        state_d   = LOCKOUT;
                        load_lock = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GRANTED: begin
                if (session_clear) state_d = IDLE;
            end
            LOCKOUT: begin
                if (lock_expire) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmp_key    <= SCRUB_KEY;
            deny_pulse <= 1'b0;
            fail_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            cmp_key    <= cmp_key_d;
            deny_pulse <= deny_d;
            fail_cnt   <= fail_d;
        end
    end

    auth_lock_timer #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .MAX_SHIFT   (MAX_SHIFT),
        .TIMER_W     (TIMER_W)
    ) u_lock_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_lock),
        .clr_lvl (clr_lvl),
        .expire  (lock_expire)
    );

endmodule

// File: tb/tb_auth_attempt_ctrl.sv
// Scoreboard bench for auth_attempt_ctrl against a comparator holding key 0xB6.
module tb_auth_attempt_ctrl;
    import citadel_auth_pkg::*;

    localparam logic [1:0] EV_KEY    = 2'd0;
    localparam logic [1:0] EV_DENY   = 2'd1;
    localparam logic [1:0] EV_GRANT  = 2'd2;
    localparam logic [1:0] EV_UNLOCK = 2'd3;
    localparam int W = 24;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  attempt_valid;
    logic [KEY_W-1:0]      attempt_key;
    logic                  attempt_ready;
    logic [KEY_W-1:0]      cmp_key;
    logic                  cmp_match;
    logic                  session_clear;
    logic                  granted;
    logic                  deny_pulse;
    logic                  locked;
    logic [FAIL_CNT_W-1:0] fail_cnt;
    auth_state_t           dbg_state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    assign cmp_match = (cmp_key == 8'hB6);

    auth_attempt_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .attempt_valid (attempt_valid),
        .attempt_key   (attempt_key),
        .attempt_ready (attempt_ready),
        .cmp_key       (cmp_key),
        .cmp_match     (cmp_match),
        .session_clear (session_clear),
        .granted       (granted),
        .deny_pulse    (deny_pulse),
        .locked        (locked),
        .fail_cnt      (fail_cnt),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    function automatic logic [W-1:0] ev(input logic [1:0] kind, input logic [21:0] payload);
        return {kind, payload};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic observe(input string name, input logic [W-1:0] act);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_%s: got 0x%0h expected no event at %0t", name, act, $time);
        end else begin
            chk(name, 32'(act), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [15:0] lock_len;
        logic        prev_locked;
        logic        prev_granted;
        lock_len     = '0;
        prev_locked  = 1'b0;
        prev_granted = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lock_len     = '0;
                prev_locked  = 1'b0;
                prev_granted = 1'b0;
            end else begin
                if (cmp_key != 8'h00) observe("key", ev(EV_KEY, 22'(cmp_key)));
                if (deny_pulse) observe("deny", ev(EV_DENY, 22'({locked, fail_cnt})));
                if (granted && !prev_granted) observe("grant", ev(EV_GRANT, 22'(fail_cnt)));
                if (!locked && prev_locked) observe("unlock", ev(EV_UNLOCK, 22'({lock_len, fail_cnt})));
                if (locked) lock_len = lock_len + 16'd1;
                else        lock_len = '0;
                prev_locked  = locked;
                prev_granted = granted;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_q_empty(input int budget);
        int i;
        for (i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL event_timeout: got %0d pending expected 0 pending at %0t", exp_q.size(), $time);
            exp_q.delete();
        end
    endtask

    task automatic send(input logic [7:0] key);
        bit done;
        done = 1'b0;
        @(posedge clk);
        #1;
        attempt_key   = key;
        attempt_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (attempt_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        attempt_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL accept_timeout: got not accepted expected accepted key 0x%0h", key);
        end
    endtask

    task automatic do_attempt(input logic [7:0] key, input bit grant,
                              input logic [3:0] exp_fail, input bit exp_lock);
        if (key != 8'h00) exp_q.push_back(ev(EV_KEY, 22'(key)));
        if (grant) exp_q.push_back(ev(EV_GRANT, 22'd0));
        else       exp_q.push_back(ev(EV_DENY, 22'({exp_lock, exp_fail})));
        send(key);
        wait_q_empty(10);
    endtask

    task automatic expect_unlock(input int len);
        exp_q.push_back(ev(EV_UNLOCK, 22'({16'(len), 4'h0})));
        wait_q_empty(len + 20);
        @(negedge clk);
        chk("ready_after_unlock", 32'(attempt_ready), 32'd1);
    endtask

    task automatic end_session();
        @(posedge clk);
        #1 session_clear = 1'b1;
        @(posedge clk);
        #1 session_clear = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int lens[4];
        lens = '{32, 64, 128, 128};
        rst_n         = 1'b0;
        attempt_valid = 1'b0;
        attempt_key   = 8'h00;
        session_clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", 32'(attempt_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmp_key", 32'(cmp_key), 32'h00);
        chk("rst_granted", 32'(granted), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_deny", 32'(deny_pulse), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("rst_ready", 32'(attempt_ready), 32'd1);

        // Correct key, then end the session.
        do_attempt(8'hB6, 1'b1, 4'd0, 1'b0);
        chk("granted_level", 32'(granted), 32'd1);
        chk("granted_no_ready", 32'(attempt_ready), 32'd0);
        end_session();
        @(negedge clk);
        chk("clear_granted", 32'(granted), 32'd0);
        chk("clear_ready", 32'(attempt_ready), 32'd1);

        // Single miss.
        do_attempt(8'h00, 1'b0, 4'd1, 1'b0);
        chk("miss_state_idle", 32'(dbg_state), 32'(IDLE));
        chk("miss_ready", 32'(attempt_ready), 32'd1);
        chk("miss_fail_cnt", 32'(fail_cnt), 32'd1);

        // Grant clears the failure count, then the base lockout.
        do_attempt(8'hB6, 1'b1, 4'd0, 1'b0);
        end_session();
        do_attempt(8'h01, 1'b0, 4'd1, 1'b0);
        do_attempt(8'h02, 1'b0, 4'd2, 1'b0);
        do_attempt(8'h03, 1'b0, 4'd3, 1'b1);
        chk("lock_fail_cnt", 32'(fail_cnt), 32'd3);
        @(posedge clk);
        #1 attempt_key = 8'h09;
        attempt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lock_no_ready", 32'(attempt_ready), 32'd0);
        end
        @(posedge clk);
        #1 attempt_valid = 1'b0;
        expect_unlock(16);
        chk("unlock_fail_cnt", 32'(fail_cnt), 32'd0);

        // Exponential backoff with saturation.
        for (int r = 0; r < 4; r++) begin
            do_attempt(8'h11, 1'b0, 4'd1, 1'b0);
            do_attempt(8'h12, 1'b0, 4'd2, 1'b0);
            do_attempt(8'h13, 1'b0, 4'd3, 1'b1);
            expect_unlock(lens[r]);
        end

        // A grant resets the backoff level.
        do_attempt(8'hB6, 1'b1, 4'd0, 1'b0);
        end_session();
        do_attempt(8'h21, 1'b0, 4'd1, 1'b0);
        do_attempt(8'h22, 1'b0, 4'd2, 1'b0);
        do_attempt(8'h23, 1'b0, 4'd3, 1'b1);
        expect_unlock(16);

        // Attempt held during a session waits for session_clear.
        do_attempt(8'hB6, 1'b1, 4'd0, 1'b0);
        exp_q.push_back(ev(EV_KEY, 22'h07));
        exp_q.push_back(ev(EV_DENY, 22'({1'b0, 4'd1})));
        @(posedge clk);
        #1 attempt_key = 8'h07;
        attempt_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("session_no_ready", 32'(attempt_ready), 32'd0);
        end
        end_session();
        @(negedge clk);
        chk("post_clear_ready", 32'(attempt_ready), 32'd1);
        chk("post_clear_granted", 32'(granted), 32'd0);
        @(posedge clk);
        #1 attempt_valid = 1'b0;
        wait_q_empty(10);

        // Reset in the middle of a level-1 lockout.
        do_attempt(8'h31, 1'b0, 4'd2, 1'b0);
        do_attempt(8'h32, 1'b0, 4'd3, 1'b1);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_lock_rst_ready", 32'(attempt_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_locked", 32'(locked), 32'd0);
        chk("rst2_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("rst2_cmp_key", 32'(cmp_key), 32'h00);
        chk("rst2_state", 32'(dbg_state), 32'(IDLE));
        do_attempt(8'h41, 1'b0, 4'd1, 1'b0);
        do_attempt(8'h42, 1'b0, 4'd2, 1'b0);
        do_attempt(8'h43, 1'b0, 4'd3, 1'b1);
        expect_unlock(16);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
